matrix_win_ctrl: RTL and testbench

- Frame/window sequencer for the 5x5 binary-matrix generator in the frame-difference motion path.
- Observes the generator's output sync triplet (vsync/href/clken) and tracks line and column position.
- Qualifies which matrix outputs hold a fully populated 5x5 window and reports each window's centre coordinate to downstream morphology/erosion stages.
- Also flags malformed frames: short or long lines, and frames that are truncated or overrun.

---
 rtl/matrix_win_ctrl.sv | 164 ++++++++++++++++
 tb/tb_matrix_win_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_win_ctrl.sv
// Frame/window sequencer for the 5x5 binary-matrix generator.
// Tracks line/column position from the generator's output sync triplet and
// marks the matrix cycles that hold a fully populated 5x5 window. Each marked
// cycle also reports the window's centre coordinate. The block further flags
// malformed lines and frames with sticky error bits.
//
// Sync-triplet semantics: every cycle with mat_href && mat_clken carries one
// matrix output. There is no backpressure; win_* qualify that same cycle.
module matrix_win_ctrl #(
   parameter int IMG_HDISP = 640,
   parameter int IMG_VDISP = 480,
   parameter int CW        = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mat_vsync,
   input  logic          mat_href,
   input  logic          mat_clken,
   output logic          win_valid,
   output logic [CW-1:0] win_x,
   output logic [CW-1:0] win_y,
   output logic          frame_start,
   output logic          frame_done,
   output logic          line_err,
   output logic          frame_err,
   output logic [1:0]    state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CW-1:0] HDISP_C   = CW'(IMG_HDISP);
   localparam logic [CW-1:0] VDISP_C   = CW'(IMG_VDISP);
   localparam logic [CW-1:0] COL_MAX   = {CW{1'b1}};
   localparam logic [CW-1:0] ROW_RUN   = CW'(4);
   localparam logic [CW-1:0] COL_FIRST = CW'(5);
   localparam logic [CW-1:0] X_OFS     = CW'(3);
   localparam logic [CW-1:0] Y_OFS     = CW'(2);

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [CW-1:0] row_q, row_d;
   logic          vsync_q, href_q;
   logic          frame_start_q, frame_start_d;
   logic          frame_done_q, frame_done_d;
   logic          line_err_q, line_err_d;
   logic          frame_err_q, frame_err_d;

   logic          vs_rise, vs_fall, href_fall, pix, in_frame;
   logic [CW-1:0] row_next;
   logic          win_hit;

   // Edge detection against the previous-cycle sync levels.
   always_comb begin
      vs_rise   = mat_vsync & ~vsync_q;
      vs_fall   = ~mat_vsync & vsync_q;
      href_fall = ~mat_href & href_q;
      pix       = mat_href & mat_clken;
      in_frame  = (state_q == ST_PRIME) || (state_q == ST_RUN);
      row_next  = row_q + CW'(1);
   end

   // Next-state, counters and flags; precedence is vsync rise > vsync fall > href fall.
   always_comb begin
      state_d       = state_q;
      col_d         = col_q;
      row_d         = row_q;
      frame_start_d = 1'b0;
      frame_done_d  = 1'b0;
      line_err_d    = line_err_q;
      frame_err_d   = frame_err_q;

      // Column count saturates so an overlong line cannot wrap back into range.
      if (pix && (col_q != COL_MAX)) begin
         col_d = col_q + CW'(1);
      end
      if (href_fall) begin
         col_d = '0;
      end

      if (vs_rise) begin
         state_d       = ST_PRIME;
         col_d         = '0;
         row_d         = '0;
         frame_start_d = 1'b1;
         if (in_frame) begin
            // Restart mid-frame: record it rather than clearing history.
            frame_err_d = 1'b1;
         end else begin
            line_err_d  = 1'b0;
            frame_err_d = 1'b0;
         end
      end else if (vs_fall) begin
         if (in_frame) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
         end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
         end
      end else if (href_fall) begin
         if (in_frame) begin
            row_d = row_next;
            if (col_q != HDISP_C) begin
               line_err_d = 1'b1;
            end
            if ((state_q == ST_PRIME) && (row_next == ROW_RUN)) begin
               state_d = ST_RUN;
            end
            if ((state_q == ST_RUN) && (row_next == VDISP_C)) begin
               state_d      = ST_DONE;
               frame_done_d = 1'b1;
            end
         end else if (state_q == ST_DONE) begin
            // Lines after the last one are not counted, only flagged.
            frame_err_d = 1'b1;
         end
      end
   end

   // State, counter and flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         col_q         <= '0;
         row_q         <= '0;
         vsync_q       <= 1'b0;
         href_q        <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         line_err_q    <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         vsync_q       <= mat_vsync;
         href_q        <= mat_href;
         frame_start_q <= frame_start_d;
         frame_done_q  <= frame_done_d;
         line_err_q    <= line_err_d;
         frame_err_q   <= frame_err_d;
      end
   end

   // Window qualification: the matrix at column k holds columns k-5..k-1, rows row-4..row.
   always_comb begin
      win_hit   = (state_q == ST_RUN) && pix &&
                  (col_q >= COL_FIRST) && (col_q <= HDISP_C);
      win_valid = win_hit;
      win_x     = win_hit ? (col_q - X_OFS) : '0;
      win_y     = win_hit ? (row_q - Y_OFS) : '0;
   end

   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign line_err    = line_err_q;
   assign frame_err   = frame_err_q;
   assign state       = state_q;

endmodule

// File: tb/tb_matrix_win_ctrl.sv
// Bench for matrix_win_ctrl with a small 8x6 frame geometry.
// A line/pixel-index model predicts every window and the frame-level flags.
module tb_matrix_win_ctrl;

   localparam int HD = 8;
   localparam int VD = 6;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          mat_vsync, mat_href, mat_clken;
   logic          win_valid;
   logic [CW-1:0] win_x, win_y;
   logic          frame_start, frame_done, line_err, frame_err;
   logic [1:0]    state;

   int n_checks = 0;
   int n_errors = 0;
   int fs_cnt   = 0;
   int fd_cnt   = 0;
   int lines_in_frame;
   int fs_base, fd_base;
   bit exp_line_err, exp_frame_err;
   logic [2*CW-1:0] exp_q[$];

   matrix_win_ctrl #(.IMG_HDISP(HD), .IMG_VDISP(VD), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .mat_vsync(mat_vsync), .mat_href(mat_href), .mat_clken(mat_clken),
      .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
      .frame_start(frame_start), .frame_done(frame_done),
      .line_err(line_err), .frame_err(frame_err), .state(state)
   );

   // Clock.
   always #5 clk = ~clk;

   // Pulse counters for the registered frame markers.
   always @(negedge clk) begin
      if (frame_start) fs_cnt++;
      if (frame_done)  fd_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected FSM state after n completed lines of an intact frame.
   function automatic logic [1:0] exp_state(input int n);
      if (n < 4)  return 2'd1;
      if (n < VD) return 2'd2;
      return 2'd3;
   endfunction

   task automatic step(input logic v, input logic h, input logic c);
      @(negedge clk);
      mat_vsync = v;
      mat_href  = h;
      mat_clken = c;
      #1;
   endtask

   task automatic drive_line(input int npix, input bit gappy);
      int   l;
      int   k;
      bit   first;
      logic ce;
      bit   exp_v;
      l = lines_in_frame;
      k = 0;
      first = 1'b1;
      while ((k < npix) || first) begin
         ce = (k < npix) && (!gappy || ($urandom_range(0, 2) == 0));
         first = 1'b0;
         step(1'b1, 1'b1, ce);
         exp_v = ce && (l >= 4) && (l < VD) && (k >= 5) && (k <= HD);
         if (exp_v) exp_q.push_back({CW'(k - 3), CW'(l - 2)});
         check("win_valid", win_valid, exp_v);
         if (win_valid) begin
            if (exp_q.size() == 0) check("win_extra", 1, 0);
            else check("win_xy", {win_x, win_y}, exp_q.pop_front());
         end else begin
            check("win_xy_idle", {win_x, win_y}, 0);
         end
         if (ce) k++;
      end
      repeat (3) step(1'b1, 1'b0, 1'b0);
      if (l < VD) begin
         if (npix != HD) exp_line_err = 1'b1;
      end else begin
         exp_frame_err = 1'b1;
      end
      lines_in_frame++;
      check("line_state", state, exp_state(lines_in_frame));
      check("line_err", line_err, exp_line_err);
      check("frame_err_line", frame_err, exp_frame_err);
   endtask

   task automatic frame_begin();
      fs_base = fs_cnt;
      fd_base = fd_cnt;
      repeat (3) step(1'b1, 1'b0, 1'b0);
      lines_in_frame = 0;
      exp_line_err   = 1'b0;
      exp_frame_err  = 1'b0;
      check("start_state", state, 2'd1);
      check("start_pulses", fs_cnt - fs_base, 1);
      check("start_line_err", line_err, 1'b0);
      check("start_frame_err", frame_err, 1'b0);
   endtask

   task automatic frame_end();
      repeat (3) step(1'b0, 1'b0, 1'b0);
      if (lines_in_frame < VD) exp_frame_err = 1'b1;
      check("end_state", state, 2'd0);
      check("end_frame_err", frame_err, exp_frame_err);
      check("end_line_err", line_err, exp_line_err);
      check("done_pulses", fd_cnt - fd_base, (lines_in_frame >= VD) ? 1 : 0);
      check("start_pulses_total", fs_cnt - fs_base, 1);
      check("exp_q_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic run_frame(input int nlines, input bit gappy, input int bad_line, input int bad_pix);
      frame_begin();
      for (int i = 0; i < nlines; i++) begin
         drive_line((i == bad_line) ? bad_pix : HD, gappy);
      end
      frame_end();
   endtask

   initial begin
      int nl;
      int bl;
      int bp;
      int fs0;
      rst = 1'b1;
      mat_vsync = 1'b0;
      mat_href  = 1'b0;
      mat_clken = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_state", state, 2'd0);
      check("rst_outs", {win_valid, win_x, win_y, frame_start, frame_done, line_err, frame_err}, 0);
      rst = 1'b0;
      repeat (2) step(1'b0, 1'b0, 1'b0);

      // Directed frames: nominal, sparse clken, short line, truncated, overrun.
      run_frame(VD, 1'b0, -1, HD);
      run_frame(VD, 1'b1, -1, HD);
      run_frame(VD, 1'b0, 2, 7);
      run_frame(3, 1'b0, -1, HD);
      run_frame(VD + 1, 1'b0, -1, HD);
      run_frame(VD, 1'b0, 4, 9);
      run_frame(VD, 1'b0, 1, 0);

      // Reset in RUN partway through line 4, with a stale line error pending.
      frame_begin();
      for (int i = 0; i < 4; i++) drive_line((i == 1) ? 7 : HD, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      mat_vsync = 1'b0;
      mat_href  = 1'b0;
      mat_clken = 1'b0;
      @(negedge clk);
      #1;
      check("midrst_state", state, 2'd0);
      check("midrst_outs", {win_valid, win_x, win_y, frame_start, frame_done, line_err, frame_err}, 0);
      rst = 1'b0;
      fs0 = fs_cnt;
      repeat (3) step(1'b0, 1'b0, 1'b0);
      check("midrst_no_pulse", fs_cnt - fs0, 0);
      check("midrst_idle", state, 2'd0);
      run_frame(VD, 1'b0, -1, HD);

      // Randomized frames.
      for (int f = 0; f < 8; f++) begin
         case ($urandom_range(0, 3))
            0:       nl = 3;
            1:       nl = VD + 1;
            default: nl = VD;
         endcase
         bl = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, VD - 1));
         case ($urandom_range(0, 2))
            0:       bp = 0;
            1:       bp = HD - 1;
            default: bp = HD + 1;
         endcase
         run_frame(nl, 1'($urandom_range(0, 1)), bl, bp);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
